lfsr_deser_chk: RTL

- Downstream consumer of the LFSR serial stream. Collects OUT/Valid bits into DATA_W-bit words, LSB first.
- Aborts frames that stall, and tags each word with even parity.
- Buffers completed words in a small FIFO behind a valid/ready handshake for the checker/logger stage.
- Flags lost words (overflow) and broken frames (frame error).

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/deser_fifo.sv | 56 +++++
 rtl/lfsr_deser_chk.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stream deserialiser: state encoding,
// default sizing constants and the word parity helper.
package lfsr_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_GAP_MAX = 3;
  localparam int DEF_DEPTH   = 2;

  // Even parity of a word (XOR of all bits); callers zero-extend to 64 bits.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/deser_fifo.sv
// Small synchronous FIFO for completed words. A push into a full FIFO is
// accepted only when a pop happens on the same edge; otherwise it is ignored.
module deser_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values from accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; cleared by reset so the FIFO reads as empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are masked on the output while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lfsr_deser_chk.sv
// Deserialises the LFSR bit stream into LSB-first words, aborts stalled
// frames, tags words with even parity and buffers them behind valid/ready.
import lfsr_pkg::*;

module lfsr_deser_chk #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GAP_MAX = DEF_GAP_MAX,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_BIT,
  input  logic              IN_VALID,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              PARITY_OUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OVERFLOW,
  output logic              FRAME_ERR
);

  localparam int CW = $clog2(DATA_W);
  localparam int GW = $clog2(GAP_MAX + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [GW-1:0]     gap_inc;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] word_ins;
  logic              ferr_q, ferr_d;
  logic              ovf_q, ovf_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  assign pop        = OUT_VALID & OUT_READY;
  assign OUT_VALID  = ~fifo_empty;
  assign DATA_OUT   = fifo_rdata[DATA_W-1:0];
  assign PARITY_OUT = fifo_rdata[DATA_W];
  assign OVERFLOW   = ovf_q;
  assign FRAME_ERR  = ferr_q;

  // Frame FSM: bit capture, completion push and stall abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    shreg_d  = shreg_q;
    ferr_d   = 1'b0;
    push     = 1'b0;
    word_ins = shreg_q;
    word_ins[cnt_q] = IN_BIT;
    gap_inc  = (gap_q == GW'(GAP_MAX)) ? gap_q : gap_q + 1'b1;
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (IN_VALID) begin
          shreg_d = {{(DATA_W-1){1'b0}}, IN_BIT};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (IN_VALID) begin
          shreg_d = word_ins;
          gap_d   = '0;
          if (cnt_q == CW'(DATA_W - 1)) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (gap_inc == GW'(GAP_MAX)) begin
          ferr_d  = 1'b1;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow: a completed word found the FIFO full with no pop.
  always_comb begin
    ovf_d = ovf_q | (push & fifo_full & ~pop);
  end

  // State and flag registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  deser_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i ({even_parity(64'(word_ins)), word_ins}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
